// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared opcodes, FSM state encoding and datapath select
//             encodings for the multi-cycle MIPS-32 controller.
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

  // Instruction register bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Controller states
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PCSource encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wait_timer
//  Purpose  : Counts stalled cycles of one memory phase and flags a timeout
//             when the memory is still not ready on the last allowed cycle.
//  Revision : 1.0  initial release
// ============================================================================
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,   // controller sits in a memory-wait state
  input  logic i_ready,    // memory completes this cycle
  output logic o_timeout   // last allowed cycle passed without ready
);

  localparam int         CW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] C_LIMIT = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Ready on the limit cycle wins, so timeout requires ready low.
  assign o_timeout = i_active && !i_ready && (count_q == C_LIMIT);

  // Count only stalled cycles; leaving the state (or timing out) clears it.
  always_comb begin
    count_d = '0;
    if (i_active && !i_ready && !o_timeout) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multi_cycle_control
//  Purpose  : Moore sequencing FSM for the multi-cycle MIPS-32 datapath with
//             memory ready handshake, bus timeout and illegal-opcode trap.
//  Revision : 1.0  initial release
// ============================================================================
module multi_cycle_control
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic             Mem_Ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             Trap,
  output logic             Bus_Error,
  output logic [CNT_W-1:0] Instr_Count
);

  state_t             state_q, state_d;
  logic               trap_q, trap_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
  logic               mem_active;
  logic               timeout;
  logic               retire;

  assign mem_active = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                      (state_q == S_MEM_WRITE);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait (
    .clk       (Clock),
    .rst_n     (Reset),
    .i_active  (mem_active),
    .i_ready   (Mem_Ready),
    .o_timeout (timeout)
  );

  assign Trap        = trap_q;
  assign Bus_Error   = bus_err_q;
  assign Instr_Count = instr_cnt_q;

  // Next-state, per-state datapath controls and status updates.
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = Mem_Ready;
        PCWrite = Mem_Ready;
        if (Mem_Ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_TRAP;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        ALUSrcB = SRCB_IMM_SH;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (Mem_Ready)    state_d = S_MEM_WB;
        else if (timeout) state_d = S_TRAP;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (Mem_Ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // Reset is asynchronous: silence every control while it is held so an
    // abandoned instruction cannot write anything.
    if (!Reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
    end

    trap_d      = trap_q | (state_d == S_TRAP);
    bus_err_d   = bus_err_q | timeout;
    instr_cnt_d = retire ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
  end

  // State and sticky status registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_FETCH;
      trap_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      trap_q      <= trap_d;
      bus_err_q   <= bus_err_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_cycle_control
//  Purpose  : Directed self-checking bench for the multi-cycle controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_cycle_control;

  // Output vector order:
  // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite
  // ALUSrcA | ALUSrcB[1:0] | ALUOp[1:0] | PCSource[1:0]
  localparam logic [15:0] E_ZERO    = 16'h0000;
  localparam logic [15:0] E_FETCH_R = {10'b1001010000, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] E_FETCH_W = {10'b0001000000, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] E_DECODE  = {10'b0000000000, 2'b11, 2'b00, 2'b00};
  localparam logic [15:0] E_MADDR   = {10'b0000000001, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] E_MREAD   = {10'b0011000000, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] E_MWB     = {10'b0000001010, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] E_MWRITE  = {10'b0010100000, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] E_EXEC    = {10'b0000000001, 2'b00, 2'b10, 2'b00};
  localparam logic [15:0] E_RWB     = {10'b0000000110, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] E_BRANCH  = {10'b0100000001, 2'b00, 2'b01, 2'b01};
  localparam logic [15:0] E_JUMP    = {10'b1000000000, 2'b00, 2'b00, 2'b10};
  localparam logic [15:0] E_ADDIEX  = {10'b0000000001, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] E_ADDIWB  = {10'b0000000010, 2'b00, 2'b00, 2'b00};

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [5:0]  Opcode = 6'b000010;
  logic        Mem_Ready = 1'b1;

  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, Trap, Bus_Error;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [31:0] Instr_Count;

  // Narrow-counter instance used only for the wrap check.
  logic        rst4_n = 1'b0;
  logic        w4_pcw, w4_pcwc, w4_iord, w4_mr, w4_mw, w4_irw;
  logic        w4_m2r, w4_rdst, w4_rw, w4_srca, w4_trap, w4_bus;
  logic [1:0]  w4_srcb, w4_aluop, w4_pcsrc;
  logic [3:0]  w4_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  multi_cycle_control #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Mem_Ready(Mem_Ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .Trap(Trap), .Bus_Error(Bus_Error),
    .Instr_Count(Instr_Count)
  );

  multi_cycle_control #(.MEM_TIMEOUT(15), .CNT_W(4)) dut_w4 (
    .Clock(Clock), .Reset(rst4_n), .Opcode(6'b000010), .Mem_Ready(1'b1),
    .PCWrite(w4_pcw), .PCWriteCond(w4_pcwc), .IorD(w4_iord),
    .MemRead(w4_mr), .MemWrite(w4_mw), .IRWrite(w4_irw),
    .MemtoReg(w4_m2r), .RegDst(w4_rdst), .RegWrite(w4_rw),
    .ALUSrcA(w4_srca), .ALUSrcB(w4_srcb), .ALUOp(w4_aluop),
    .PCSource(w4_pcsrc), .Trap(w4_trap), .Bus_Error(w4_bus),
    .Instr_Count(w4_cnt)
  );

  logic [15:0] outs;
  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  // Single comparison point.
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive Mem_Ready, let outputs settle, compare the control vector.
  task automatic chk_now(input string tag, input logic rdy, input logic [15:0] exp);
    Mem_Ready = rdy;
    #1;
    check_eq(tag, {16'h0, outs}, {16'h0, exp});
  endtask

  // Advance one clock and check at the falling edge.
  task automatic cyc(input string tag, input logic rdy, input logic [15:0] exp);
    @(negedge Clock);
    chk_now(tag, rdy, exp);
  endtask

  initial begin
    // ---- Reset state ----
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk_now("rst_outs", 1'b1, E_ZERO);
    check_eq("rst_cnt", Instr_Count, 32'd0);
    check_eq("rst_trap", {31'd0, Trap}, 32'd0);
    check_eq("rst_bus", {31'd0, Bus_Error}, 32'd0);

    @(negedge Clock);
    Reset = 1'b1;
    chk_now("rel_fetch", 1'b1, E_FETCH_R);
    cyc("j0_dec", 1'b1, E_DECODE);
    cyc("j0_jump", 1'b1, E_JUMP);
    Opcode = 6'b000000;
    cyc("r0_fetch", 1'b1, E_FETCH_R);
    check_eq("cnt_after_j", Instr_Count, 32'd1);
    cyc("r0_dec", 1'b1, E_DECODE);
    cyc("r0_exec", 1'b1, E_EXEC);
    // Asynchronous reset mid-EXECUTE
    Reset = 1'b0;
    chk_now("midrst_outs", 1'b1, E_ZERO);
    check_eq("midrst_cnt", Instr_Count, 32'd0);
    cyc("midrst_hold", 1'b1, E_ZERO);
    @(negedge Clock);
    Reset = 1'b1;
    chk_now("rel2_fetch", 1'b1, E_FETCH_R);

    // ---- add, lw, sw, beq, j, addi with Mem_Ready high ----
    cyc("add_dec", 1'b1, E_DECODE);
    cyc("add_exec", 1'b1, E_EXEC);
    cyc("add_wb", 1'b1, E_RWB);
    Opcode = 6'b100011;
    cyc("lw_fetch", 1'b1, E_FETCH_R);
    cyc("lw_dec", 1'b1, E_DECODE);
    cyc("lw_addr", 1'b1, E_MADDR);
    cyc("lw_read", 1'b1, E_MREAD);
    cyc("lw_wb", 1'b1, E_MWB);
    Opcode = 6'b101011;
    cyc("sw_fetch", 1'b1, E_FETCH_R);
    cyc("sw_dec", 1'b1, E_DECODE);
    cyc("sw_addr", 1'b1, E_MADDR);
    cyc("sw_write", 1'b1, E_MWRITE);
    Opcode = 6'b000100;
    cyc("beq_fetch", 1'b1, E_FETCH_R);
    cyc("beq_dec", 1'b1, E_DECODE);
    cyc("beq_br", 1'b1, E_BRANCH);
    Opcode = 6'b000010;
    cyc("j_fetch", 1'b1, E_FETCH_R);
    cyc("j_dec", 1'b1, E_DECODE);
    cyc("j_jump", 1'b1, E_JUMP);
    Opcode = 6'b001000;
    cyc("addi_fetch", 1'b1, E_FETCH_R);
    cyc("addi_dec", 1'b1, E_DECODE);
    cyc("addi_ex", 1'b1, E_ADDIEX);
    cyc("addi_wb", 1'b1, E_ADDIWB);
    Opcode = 6'b100011;
    cyc("lw2_fetch", 1'b1, E_FETCH_R);
    check_eq("cnt_six", Instr_Count, 32'd6);

    // ---- lw with three stalled MEM_READ cycles ----
    cyc("lw2_dec", 1'b1, E_DECODE);
    cyc("lw2_addr", 1'b1, E_MADDR);
    for (int i = 0; i < 3; i++) cyc("lw2_stall", 1'b0, E_MREAD);
    cyc("lw2_read", 1'b1, E_MREAD);
    cyc("lw2_wb", 1'b1, E_MWB);
    Opcode = 6'b001000;
    // ---- FETCH ready arrives on cycle 15: completes, no error ----
    cyc("to_f1", 1'b0, E_FETCH_W);
    check_eq("cnt_seven", Instr_Count, 32'd7);
    for (int i = 2; i <= 14; i++) cyc("to_fw", 1'b0, E_FETCH_W);
    cyc("to_f15_rdy", 1'b1, E_FETCH_R);
    cyc("to_dec", 1'b1, E_DECODE);
    check_eq("to_nobus", {31'd0, Bus_Error}, 32'd0);
    check_eq("to_notrap", {31'd0, Trap}, 32'd0);
    cyc("to_addi_ex", 1'b1, E_ADDIEX);
    cyc("to_addi_wb", 1'b1, E_ADDIWB);

    // ---- Illegal opcode ----
    Opcode = 6'b111111;
    cyc("ill_fetch", 1'b1, E_FETCH_R);
    cyc("ill_dec", 1'b1, E_DECODE);
    check_eq("ill_dec_trap", {31'd0, Trap}, 32'd0);
    for (int i = 0; i < 20; i++) cyc("ill_trap", i[0], E_ZERO);
    check_eq("ill_trap_flag", {31'd0, Trap}, 32'd1);
    check_eq("ill_bus", {31'd0, Bus_Error}, 32'd0);
    check_eq("ill_cnt", Instr_Count, 32'd8);

    // ---- FETCH timeout: ready never arrives ----
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check_eq("rst3_trap", {31'd0, Trap}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    chk_now("bt_f1", 1'b0, E_FETCH_W);
    for (int i = 2; i <= 15; i++) cyc("bt_fw", 1'b0, E_FETCH_W);
    check_eq("bt_bus_pre", {31'd0, Bus_Error}, 32'd0);
    cyc("bt_trap", 1'b1, E_ZERO);
    check_eq("bt_bus", {31'd0, Bus_Error}, 32'd1);
    check_eq("bt_trapflag", {31'd0, Trap}, 32'd1);
    check_eq("bt_cnt", Instr_Count, 32'd0);

    // ---- CNT_W = 4 wrap: jumps retire every 3 cycles ----
    @(negedge Clock);
    rst4_n = 1'b1;
    repeat (45) @(posedge Clock);
    @(negedge Clock);
    check_eq("w4_cnt15", {28'd0, w4_cnt}, 32'd15);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_eq("w4_cnt0", {28'd0, w4_cnt}, 32'd0);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_eq("w4_cnt1", {28'd0, w4_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
